ag_vram_arb: RTL and testbench
==============================

Name: ag_vram_arb

Overview:
- Single-clock, parametrised shared video/CPU RAM. It generalises the fixed 32Kx8/16Kx16 dual-view memory.
- One physical synchronous RAM port is time-shared between two users:
  - a byte-wide CPU port with a req/ack handshake;
  - a video burst fetcher that streams RATIO-byte words into a show-ahead prefetch FIFO.
- The block sits between the 6502 bus glue and the video controller.
- Video has priority, bounded by a CPU starvation limit.

Parameters:
- ADDR_W, 14: video word address width; memory holds 2^ADDR_W words.
- RATIO, 2: bytes per video word (power of 2, 1..4); LG_R = log2(RATIO).
- FIFO_DEPTH, 4: prefetch FIFO entries (power of 2, >=2).
- CPU_MAX_WAIT, 3: consecutive denied CPU cycles before the CPU is forced a grant.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- cpu_req  in  1  access request; hold with addr/we/di until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W+LG_R  byte address; low LG_R bits select the byte lane.
- cpu_di  in  8  write data.
- cpu_do  out  8  read data; valid in the cpu_ack cycle.
- cpu_ack  out  1  one-cycle completion pulse.
- vid_start  in  1  pulse; loads vid_base/vid_len and begins a burst.
- vid_base  in  ADDR_W  first word address of the burst.
- vid_len  in  8  burst length in words; 0 means 256.
- vid_pop  in  1  consume the FIFO head.
- vid_data  out  8*RATIO  FIFO head word (show-ahead).
- vid_valid  out  1  FIFO not empty.
- vid_busy  out  1  burst in progress.
- vid_underrun  out  1  sticky; set by a pop while empty, cleared by vid_start or RST.

Behaviour:
- Reset values: cpu_do=0, cpu_ack=0, vid_data=0, vid_valid=0, vid_busy=0, vid_underrun=0. RST also clears the FIFO, the remaining-word count, in-flight flags and the wait counter. RAM contents are unaffected by reset.
- RAM timing: one access per cycle; read latency 1 cycle.
- Byte-lane order:
  - lane k = cpu_addr[LG_R-1:0] maps to vid_data[8*(RATIO-k)-1 -: 8], so lane 0 is the most significant byte.
  - A CPU write touches only that lane.
  - Word address = cpu_addr[ADDR_W+LG_R-1:LG_R].
- Arbiter, evaluated each cycle:
  - vid_elig = busy AND remaining>0 AND (fifo_count + vid_inflight) < FIFO_DEPTH.
  - cpu_elig = cpu_req AND NOT cpu_inflight.
  - If cpu_wait >= CPU_MAX_WAIT and cpu_elig: grant CPU.
  - Else if vid_elig: grant video.
  - Else if cpu_elig: grant CPU.
  - Else idle.
- cpu_wait counter:
  - increments (saturating) each cycle cpu_elig is denied;
  - clears on a CPU grant or when cpu_req is low.
- CPU handshake:
  - Grant at cycle T gives cpu_ack=1 at T+1, with cpu_do = selected lane for reads (cpu_do holds its last value on writes).
  - The CPU is ineligible at T+1.
  - If cpu_req is still high at T+2, it is treated as a new access.
  - Minimum CPU access: 2 cycles.
- Video fetch:
  - A grant at T reads word (base+issued) mod 2^ADDR_W and pushes it into the FIFO at T+1.
  - remaining decrements at grant; the address wraps at 2^ADDR_W.
  - vid_busy drops in the cycle after the last word's push.
- FIFO:
  - vid_valid = (count != 0).
  - A pop while valid advances the head.
  - Push and pop in the same cycle leave count unchanged.
  - A pop while empty is ignored and sets vid_underrun.
  - The credit check ignores a same-cycle pop (conservative), so the FIFO can never overflow.
- vid_start:
  - When idle: loads base and len; busy=1 next cycle.
  - When busy (restart): flushes the FIFO, suppresses the push of any in-flight fetch, then loads the new burst.
  - vid_start with a same-cycle vid_pop: the start wins and the pop is ignored.
  - A CPU access in flight during a restart completes normally.
- Write/read collision: a CPU write and a video read never share a cycle (single port). A video fetch issued after a CPU write grant sees the new data.
- RST mid-burst: everything returns to the reset state immediately. A pending CPU access is dropped with no ack.

Test Plan:
- RATIO=2: CPU writes 0xA5 at byte 0x0000 and 0x3C at byte 0x0001, then bursts base=0 len=1 -> vid_data=0xA53C, vid_valid=1, vid_busy falls after the push.
- CPU read of byte 0x0001 with video idle -> cpu_ack exactly 1 cycle after grant, cpu_do=0x3C; req held for 3 more cycles -> a second ack 2 cycles later.
- Burst len=10 with no pops and FIFO_DEPTH=4 -> exactly 4 entries and no further fetches; popping one per cycle -> all 10 words in address order, then busy=0.
- Burst base=0x3FFE len=4 (ADDR_W=14) -> words from addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Continuous cpu_req during a long burst with pops every cycle, CPU_MAX_WAIT=3 -> the CPU is granted within 4 cycles of requesting; no FIFO overflow; video order intact.
- Pop while empty -> vid_underrun=1 until the next vid_start. Restart mid-burst with a fetch in flight -> the old word never appears and the first output is the new base's word. RST asserted mid-burst -> all outputs 0 and no cpu_ack.

Source files
------------

// File: rtl/ag_vram_arb.sv
// Shared video/CPU RAM. One single-port synchronous RAM is time-shared between
// a byte-wide CPU port (req/ack) and a video burst fetcher that streams
// RATIO-byte words into a show-ahead prefetch FIFO. Video wins arbitration
// unless the CPU has been denied for CPU_MAX_WAIT consecutive cycles.
module ag_vram_arb #(
  parameter int ADDR_W       = 14,
  parameter int RATIO        = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int CPU_MAX_WAIT = 3,
  parameter int LG_R         = $clog2(RATIO)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W+LG_R-1:0] cpu_addr,
  input  logic [7:0]             cpu_di,
  output logic [7:0]             cpu_do,
  output logic                   cpu_ack,
  input  logic                   vid_start,
  input  logic [ADDR_W-1:0]      vid_base,
  input  logic [7:0]             vid_len,
  input  logic                   vid_pop,
  output logic [8*RATIO-1:0]     vid_data,
  output logic                   vid_valid,
  output logic                   vid_busy,
  output logic                   vid_underrun
);

  localparam int LANE_W = (LG_R > 0) ? LG_R : 1;
  localparam int DW     = 8 * RATIO;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WAIT_W = (CPU_MAX_WAIT > 0) ? $clog2(CPU_MAX_WAIT + 1) : 1;

  // RAM and FIFO storage carry no reset; their visibility is gated by flops.
  logic [DW-1:0] ram      [0:(1<<ADDR_W)-1];
  logic [DW-1:0] fifo_mem [0:FIFO_DEPTH-1];
  logic [DW-1:0] ram_rdata_q;

  logic              busy_q, busy_d;
  logic [8:0]        remaining_q, remaining_d;
  logic [ADDR_W-1:0] vid_addr_q, vid_addr_d;
  logic              vid_inflight_q, vid_inflight_d;
  logic              cpu_inflight_q, cpu_inflight_d;
  logic              cpu_rd_q, cpu_rd_d;
  logic [LANE_W-1:0] cpu_lane_q, cpu_lane_d;
  logic [7:0]        cpu_do_q, cpu_do_d;
  logic [WAIT_W-1:0] wait_left_q, wait_left_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              underrun_q, underrun_d;

  logic              vid_elig, cpu_elig, cpu_force, cpu_grant, vid_grant;
  logic              push, pop, ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr, cpu_waddr;
  logic [LANE_W-1:0] cpu_lane;
  logic [7:0]        cpu_rd_byte;

  if (LG_R > 0) begin : g_lane
    assign cpu_lane = cpu_addr[LANE_W-1:0];
  end else begin : g_nolane
    assign cpu_lane = '0;
  end
  assign cpu_waddr = cpu_addr[ADDR_W+LG_R-1:LG_R];

  // Arbitration: starving CPU first, then video with FIFO credit, then CPU.
  // The credit check ignores a same-cycle pop, and a vid_start cycle never
  // issues a fetch so nothing from the old burst can land after the flush.
  always_comb begin
    vid_elig  = busy_q && (remaining_q != 9'd0) && !vid_start &&
                (({1'b0, count_q} + (PTR_W+2)'(vid_inflight_q)) < (PTR_W+2)'(FIFO_DEPTH));
    cpu_elig  = cpu_req && !cpu_inflight_q;
    cpu_force = cpu_elig && (wait_left_q == '0);
    cpu_grant = cpu_force || (cpu_elig && !vid_elig);
    vid_grant = vid_elig && !cpu_force;
    ram_addr  = cpu_grant ? cpu_waddr : vid_addr_q;
    ram_we    = cpu_grant && cpu_we;
    ram_re    = vid_grant || (cpu_grant && !cpu_we);
    push      = vid_inflight_q && !vid_start;
    pop       = vid_pop && (count_q != '0) && !vid_start;
  end

  // Single RAM port: byte-lane write or full-word read, read latency one cycle.
  always_ff @(posedge CLK) begin
    if (ram_we) ram[ram_addr][8*(RATIO-1-int'(cpu_lane)) +: 8] <= cpu_di;
    if (ram_re) ram_rdata_q <= ram[ram_addr];
  end

  // FIFO storage write; the fetched word arrives the cycle after its grant.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_q] <= ram_rdata_q;
  end

  // CPU read data is taken straight from the RAM output in the ack cycle and
  // held afterwards, so writes leave cpu_do unchanged.
  always_comb begin
    cpu_rd_byte = ram_rdata_q[8*(RATIO-1-int'(cpu_lane_q)) +: 8];
    cpu_do      = cpu_rd_q ? cpu_rd_byte : cpu_do_q;
  end

  // Next-state for burst, FIFO, CPU handshake and starvation timer.
  always_comb begin
    busy_d         = busy_q;
    remaining_d    = remaining_q;
    vid_addr_d     = vid_addr_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    underrun_d     = underrun_q;
    vid_inflight_d = vid_grant;
    cpu_inflight_d = cpu_grant;
    cpu_rd_d       = cpu_grant && !cpu_we;
    cpu_lane_d     = cpu_grant ? cpu_lane : cpu_lane_q;
    cpu_do_d       = cpu_do;
    wait_left_d    = wait_left_q;

    if (vid_start) begin
      busy_d      = 1'b1;
      remaining_d = (vid_len == 8'd0) ? 9'd256 : {1'b0, vid_len};
      vid_addr_d  = vid_base;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      underrun_d  = 1'b0;
    end else begin
      if (vid_grant) begin
        remaining_d = remaining_q - 9'd1;
        vid_addr_d  = vid_addr_q + ADDR_W'(1);
      end
      // remaining hits zero at the last grant; its push happens this cycle.
      if (busy_q && (remaining_q == 9'd0)) busy_d = 1'b0;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
      if (vid_pop && (count_q == '0)) underrun_d = 1'b1;
    end

    // Down-counter to forced grant; holds while the CPU access is in flight.
    if (!cpu_req || cpu_grant)
      wait_left_d = WAIT_W'(CPU_MAX_WAIT);
    else if (cpu_elig && (wait_left_q != '0))
      wait_left_d = wait_left_q - WAIT_W'(1);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q         <= 1'b0;
      remaining_q    <= 9'd0;
      vid_addr_q     <= '0;
      vid_inflight_q <= 1'b0;
      cpu_inflight_q <= 1'b0;
      cpu_rd_q       <= 1'b0;
      cpu_lane_q     <= '0;
      cpu_do_q       <= 8'd0;
      wait_left_q    <= WAIT_W'(CPU_MAX_WAIT);
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      underrun_q     <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      remaining_q    <= remaining_d;
      vid_addr_q     <= vid_addr_d;
      vid_inflight_q <= vid_inflight_d;
      cpu_inflight_q <= cpu_inflight_d;
      cpu_rd_q       <= cpu_rd_d;
      cpu_lane_q     <= cpu_lane_d;
      cpu_do_q       <= cpu_do_d;
      wait_left_q    <= wait_left_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      underrun_q     <= underrun_d;
    end
  end

  assign cpu_ack      = cpu_inflight_q;
  assign vid_valid    = (count_q != '0);
  assign vid_data     = vid_valid ? fifo_mem[rd_ptr_q] : '0;
  assign vid_busy     = busy_q;
  assign vid_underrun = underrun_q;

endmodule

// File: tb/tb_ag_vram_arb.sv
// Self-checking bench for ag_vram_arb. A shadow memory tracks every CPU write;
// each burst pushes its expected word addresses onto a scoreboard queue, and
// each word the DUT presents is popped and compared against the shadow copy.
module tb_ag_vram_arb;
  localparam int ADDR_W = 14;
  localparam int RATIO = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int CPU_MAX_WAIT = 3;

  logic              CLK = 1'b0;
  logic              RST;
  logic              cpu_req, cpu_we;
  logic [ADDR_W:0]   cpu_addr;
  logic [7:0]        cpu_di, cpu_do;
  logic              cpu_ack;
  logic              vid_start, vid_pop;
  logic [ADDR_W-1:0] vid_base;
  logic [7:0]        vid_len;
  logic [15:0]       vid_data;
  logic              vid_valid, vid_busy, vid_underrun;

  int n_pass = 0;
  int n_total = 0;

  logic [15:0]       smem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] exp_q [$];

  always #5 CLK = ~CLK;

  ag_vram_arb #(.ADDR_W(ADDR_W), .RATIO(RATIO), .FIFO_DEPTH(FIFO_DEPTH),
                .CPU_MAX_WAIT(CPU_MAX_WAIT)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_di(cpu_di),
    .cpu_do(cpu_do), .cpu_ack(cpu_ack),
    .vid_start(vid_start), .vid_base(vid_base), .vid_len(vid_len),
    .vid_pop(vid_pop), .vid_data(vid_data), .vid_valid(vid_valid),
    .vid_busy(vid_busy), .vid_underrun(vid_underrun)
  );

  task automatic tick();
    @(negedge CLK);
  endtask

  // Drives one CPU access starting at the current negedge; returns the number
  // of negedges until cpu_ack was seen (50 means it never came).
  task automatic cpu_access(input logic we, input logic [ADDR_W:0] addr,
                            input logic [7:0] di, output int lat);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_di = di; lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!cpu_ack && lat < 50);
    cpu_req = 1'b0;
  endtask

  task automatic write_byte(input logic [ADDR_W:0] addr, input logic [7:0] d);
    int lat;
    cpu_access(1'b1, addr, d, lat);
    n_total++;
    if (lat >= 50) $display("FAIL write_ack: no ack for addr %h", addr);
    else n_pass++;
    if (addr[0] == 1'b0) smem[addr[ADDR_W:1]][15:8] = d;
    else                 smem[addr[ADDR_W:1]][7:0]  = d;
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] w, input logic [15:0] d);
    write_byte({w, 1'b0}, d[15:8]);
    write_byte({w, 1'b1}, d[7:0]);
  endtask

  task automatic start_burst(input logic [ADDR_W-1:0] base, input logic [7:0] len,
                             input logic pop_too);
    int n;
    n = (len == 8'd0) ? 256 : int'(len);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(base + ADDR_W'(i));
    vid_start = 1'b1; vid_base = base; vid_len = len; vid_pop = pop_too;
    tick();
    vid_start = 1'b0; vid_pop = 1'b0;
  endtask

  // Pops every valid word and checks it against the scoreboard.
  task automatic drain(input int max_cycles);
    logic [ADDR_W-1:0] a;
    for (int c = 0; c < max_cycles && exp_q.size() > 0; c++) begin
      if (vid_valid) begin
        a = exp_q.pop_front();
        n_total++;
        if (vid_data !== smem[a])
          $display("FAIL vid_word @%h: got %h expected %h", a, vid_data, smem[a]);
        else n_pass++;
        vid_pop = 1'b1;
      end else begin
        vid_pop = 1'b0;
      end
      tick();
    end
    vid_pop = 1'b0;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL drain_timeout: %0d words missing", exp_q.size());
    else n_pass++;
  endtask

  task automatic check_idle(input string name);
    n_total++;
    if (vid_valid !== 1'b0 || vid_busy !== 1'b0)
      $display("FAIL %s: valid=%b busy=%b expected 0 0", name, vid_valid, vid_busy);
    else n_pass++;
  endtask

  task automatic check_all_zero(input string name);
    n_total++;
    if (cpu_do !== 8'd0 || cpu_ack !== 1'b0 || vid_data !== 16'd0 ||
        vid_valid !== 1'b0 || vid_busy !== 1'b0 || vid_underrun !== 1'b0)
      $display("FAIL %s: do=%h ack=%b data=%h valid=%b busy=%b und=%b expected all 0",
               name, cpu_do, cpu_ack, vid_data, vid_valid, vid_busy, vid_underrun);
    else n_pass++;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) tick();
    check_all_zero("reset_outputs");
    RST = 1'b0;
    tick();
    check_all_zero("after_reset_release");
  endtask

  task automatic test_basic();
    logic [ADDR_W-1:0] a;
    write_byte(15'h0000, 8'hA5);
    write_byte(15'h0001, 8'h3C);
    start_burst(14'h0000, 8'd1, 1'b0);
    n_total++;
    if (vid_busy !== 1'b1) $display("FAIL basic_busy: got %b expected 1", vid_busy);
    else n_pass++;
    repeat (2) tick();
    a = exp_q.pop_front();
    n_total++;
    if (vid_valid !== 1'b1 || vid_data !== 16'hA53C || smem[a] !== 16'hA53C)
      $display("FAIL basic_word: valid=%b data=%h expected 1 a53c", vid_valid, vid_data);
    else n_pass++;
    n_total++;
    if (vid_busy !== 1'b0) $display("FAIL basic_busy_fall: got %b expected 0", vid_busy);
    else n_pass++;
    vid_pop = 1'b1;
    tick();
    vid_pop = 1'b0;
    check_idle("basic_drained");
  endtask

  task automatic test_cpu_read();
    logic [1:0] acks;
    int lat;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0001;
    tick();
    n_total++;
    if (cpu_ack !== 1'b1 || cpu_do !== 8'h3C)
      $display("FAIL read_first: ack=%b do=%h expected 1 3c", cpu_ack, cpu_do);
    else n_pass++;
    tick();
    acks[0] = cpu_ack;
    tick();
    acks[1] = cpu_ack;
    n_total++;
    if (acks !== 2'b10 || cpu_do !== 8'h3C)
      $display("FAIL read_second: acks=%b do=%h expected 10 3c", acks, cpu_do);
    else n_pass++;
    cpu_req = 1'b0;
    tick();
    n_total++;
    if (cpu_ack !== 1'b0) $display("FAIL read_release: ack=%b expected 0", cpu_ack);
    else n_pass++;
    cpu_access(1'b0, 15'h0000, 8'h00, lat);
    n_total++;
    if (lat != 1 || cpu_do !== 8'hA5)
      $display("FAIL read_lane0: lat=%0d do=%h expected 1 a5", lat, cpu_do);
    else n_pass++;
  endtask

  task automatic test_credit();
    int lat;
    for (int i = 0; i < 10; i++) write_word(14'h0100 + 14'(i), 16'hC000 + 16'(i * 16'h0111));
    start_burst(14'h0100, 8'd10, 1'b0);
    repeat (12) tick();
    n_total++;
    if (vid_valid !== 1'b1 || vid_busy !== 1'b1)
      $display("FAIL credit_hold: valid=%b busy=%b expected 1 1", vid_valid, vid_busy);
    else n_pass++;
    // Words 4 and 5 must not have been fetched yet: rewrite them now. With
    // the video side out of credit, the CPU gets the port immediately.
    cpu_access(1'b1, {14'h0104, 1'b0}, 8'hEE, lat);
    smem[14'h0104][15:8] = 8'hEE;
    n_total++;
    if (lat != 1) $display("FAIL credit_cpu_lat: got %0d expected 1", lat);
    else n_pass++;
    write_byte({14'h0105, 1'b1}, 8'h77);
    drain(80);
    repeat (3) tick();
    check_idle("credit_done");
  endtask

  task automatic test_wrap();
    write_word(14'h3FFE, 16'h1234);
    write_word(14'h3FFF, 16'h5678);
    write_word(14'h0001, 16'h9ABC);
    start_burst(14'h3FFE, 8'd4, 1'b0);
    drain(40);
    repeat (3) tick();
    check_idle("wrap_done");
  endtask

  task automatic test_starve();
    for (int i = 0; i < 40; i++) write_word(14'h0200 + 14'(i), {8'(i + 8'h40), 8'(8'hB0 - i)});
    start_burst(14'h0200, 8'd40, 1'b0);
    fork
      drain(300);
      begin
        int lat;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
          cpu_access(1'b0, {14'h0200 + 14'(i), 1'b0}, 8'h00, lat);
          // A back-to-back request spends its ack cycle ineligible first.
          n_total++;
          if (lat > ((i == 0) ? 4 : 5))
            $display("FAIL starve_lat[%0d]: got %0d limit %0d", i, lat, (i == 0) ? 4 : 5);
          else n_pass++;
          n_total++;
          if (cpu_do !== smem[14'h0200 + 14'(i)][15:8])
            $display("FAIL starve_data[%0d]: got %h expected %h", i, cpu_do,
                     smem[14'h0200 + 14'(i)][15:8]);
          else n_pass++;
        end
      end
    join
    repeat (3) tick();
    check_idle("starve_done");
  endtask

  task automatic test_underrun();
    n_total++;
    if (vid_underrun !== 1'b0) $display("FAIL underrun_clear: got %b expected 0", vid_underrun);
    else n_pass++;
    vid_pop = 1'b1;
    tick();
    vid_pop = 1'b0;
    repeat (3) tick();
    n_total++;
    if (vid_underrun !== 1'b1) $display("FAIL underrun_sticky: got %b expected 1", vid_underrun);
    else n_pass++;
  endtask

  task automatic test_restart();
    for (int i = 0; i < 8; i++) write_word(14'h0300 + 14'(i), 16'hD000 + 16'(i));
    start_burst(14'h0300, 8'd8, 1'b0);
    n_total++;
    if (vid_underrun !== 1'b0) $display("FAIL start_clears_underrun: got %b expected 0", vid_underrun);
    else n_pass++;
    tick();
    // First fetch of the old burst is in flight now; restart with a pop.
    start_burst(14'h0100, 8'd2, 1'b1);
    n_total++;
    if (vid_underrun !== 1'b0) $display("FAIL restart_pop_ignored: got %b expected 0", vid_underrun);
    else n_pass++;
    drain(40);
    repeat (3) tick();
    check_idle("restart_done");
  endtask

  task automatic test_rst_mid();
    start_burst(14'h0200, 8'd40, 1'b0);
    repeat (3) tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = {14'h0201, 1'b1};
    tick();
    RST = 1'b1;
    #1;
    check_all_zero("rst_immediate");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all_zero("rst_held");
    end
    cpu_req = 1'b0;
    exp_q.delete();
    tick();
    RST = 1'b0;
    repeat (2) tick();
    check_all_zero("rst_released");
  endtask

  initial begin
    RST = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_di = '0;
    vid_start = 1'b0; vid_base = '0; vid_len = '0; vid_pop = 1'b0;
    test_reset();
    test_basic();
    test_cpu_read();
    test_credit();
    test_wrap();
    test_starve();
    test_underrun();
    test_restart();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
